multiplier_seq_nbit: RTL

MULTIPLIER_SEQ_NBIT -- requirements
Module: multiplier_seq_nbit

---
 rtl/pim_mult_pkg.sv | 24 ++
 rtl/adder_nbit.sv | 32 +++
 rtl/multiplier_seq_nbit.sv | 119 +++++++++++
 3 files changed

// File: rtl/pim_mult_pkg.sv
//==============================================================================
// pim_mult_pkg : shared FSM encoding and operand-width legality check
// Revision     : 1.0
//==============================================================================
`default_nettype none

package pim_mult_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_nbit.sv
//==============================================================================
// adder_nbit : N-bit adder, behavioural (IMPL_TYPE=0) or explicit ripple carry
// Revision   : 1.0
//==============================================================================
`default_nettype none

module adder_nbit #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    if (IMPL_TYPE == 0) begin : g_behav
        assign sum_o = a_i + b_i;
    end else begin : g_ripple
        logic [WIDTH-1:0] w_carry;
        assign w_carry[0] = 1'b0;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum_o[i] = a_i[i] ^ b_i[i] ^ w_carry[i];
            // The final carry-out is dropped: callers size the adder to hold it.
            if (i < WIDTH - 1) begin : g_carry
                assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/multiplier_seq_nbit.sv
//==============================================================================
// multiplier_seq_nbit : radix-2 shift-add multiplier, signed/unsigned operands
// Revision            : 1.0
//==============================================================================
`default_nettype none

module multiplier_seq_nbit
    import pim_mult_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("multiplier_seq_nbit: WIDTH out of legal range");
    end

    localparam int                 CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

    state_t               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 sign_q;
    logic [2*WIDTH-1:0]   p_q;

    logic [WIDTH-1:0]     a_mag_d;
    logic [WIDTH-1:0]     b_mag_d;
    logic [WIDTH:0]       add_a_d;
    logic [WIDTH:0]       add_b_d;
    logic [WIDTH:0]       add_sum_d;
    logic [2*WIDTH:0]     shift_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_d;

    // Magnitude of the most negative value wraps to itself, which read unsigned is exact.
    assign a_mag_d = (signed_mode && A[WIDTH-1]) ? (~A + ONE_W) : A;
    assign b_mag_d = (signed_mode && B[WIDTH-1]) ? (~B + ONE_W) : B;

    assign add_a_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign add_b_d = mplier_q[0] ? {1'b0, mcand_q} : '0;

    adder_nbit #(
        .WIDTH     (WIDTH + 1),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_adder (
        .a_i   (add_a_d),
        .b_i   (add_b_d),
        .sum_o (add_sum_d)
    );

    assign shift_d = {add_sum_d, acc_q[WIDTH-1:0]};
    assign acc_d   = shift_d[2*WIDTH:1];
    assign prod_d  = sign_q ? (~acc_d + ONE_2W) : acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            p_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= a_mag_d;
                        mplier_q <= b_mag_d;
                        sign_q   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    // Last step: P takes the post-step value so no extra cycle is spent.
                    if (cnt_q == CNT_LAST) begin
                        p_q     <= prod_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign P         = p_q;

endmodule

`default_nettype wire
